// File: rtl/param_reader.sv
// Streams a ROWS x COLS matrix store (row-major) followed by a VLEN vector store
// out through a valid/ready port, one beat per cycle when the consumer keeps up.
module param_reader #(
    parameter int ROWS = 2,
    parameter int COLS = 4,
    parameter int VLEN = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        abort,
    output logic [1:0]  mat_seli,
    output logic [3:0]  mat_selj,
    input  logic [15:0] mat_param,
    output logic [3:0]  vec_sel,
    input  logic [15:0] vec_param,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        out_is_vec,
    output logic [3:0]  out_idx,
    output logic        out_last,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, MAT, VEC, DRAIN} state_t;

    localparam logic [1:0] I_LAST = 2'(ROWS - 1);
    localparam logic [3:0] J_LAST = 4'(COLS - 1);
    localparam logic [3:0] K_LAST = 4'(VLEN - 1);
    localparam logic [3:0] COLS_W = 4'(COLS);

    state_t     state;
    state_t     state_next;
    logic [1:0] i;
    logic [3:0] j;
    logic [3:0] k;
    logic       ld;
    logic       mat_end;
    logic       vec_end;

    // A new beat may be loaded whenever the output register is empty or being drained.
    assign ld      = !out_valid || out_ready;
    assign mat_end = (i == I_LAST) && (j == J_LAST);
    assign vec_end = (k == K_LAST);

    assign busy     = (state != IDLE);
    assign mat_seli = (state == MAT) ? i : 2'd0;
    assign mat_selj = (state == MAT) ? j : 4'd0;
    assign vec_sel  = (state == VEC) ? k : 4'd0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start && !abort)   state_next = MAT;
            MAT:     if (abort)             state_next = IDLE;
                     else if (ld && mat_end) state_next = VEC;
            VEC:     if (abort)             state_next = IDLE;
                     else if (ld && vec_end) state_next = DRAIN;
            DRAIN:   if (abort || out_ready) state_next = IDLE;
            default:                        state_next = IDLE;
        endcase
    end

    // Abort outranks loading; the output register only changes on a load or a drain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            i          <= 2'd0;
            j          <= 4'd0;
            k          <= 4'd0;
            out_valid  <= 1'b0;
            out_data   <= 16'd0;
            out_is_vec <= 1'b0;
            out_idx    <= 4'd0;
            out_last   <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state != IDLE && abort) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
                i         <= 2'd0;
                j         <= 4'd0;
                k         <= 4'd0;
            end else begin
                case (state)
                    MAT: if (ld) begin
                        out_data   <= mat_param;
                        out_is_vec <= 1'b0;
                        out_idx    <= ({2'b00, i} * COLS_W) + j;
                        out_valid  <= 1'b1;
                        k          <= 4'd0;
                        if (j == J_LAST) begin
                            j <= 4'd0;
                            i <= (i == I_LAST) ? 2'd0 : i + 2'd1;
                        end else begin
                            j <= j + 4'd1;
                        end
                    end
                    VEC: if (ld) begin
                        out_data   <= vec_param;
                        out_is_vec <= 1'b1;
                        out_idx    <= k;
                        out_valid  <= 1'b1;
                        if (vec_end) begin
                            k        <= 4'd0;
                            out_last <= 1'b1;
                        end else begin
                            k <= k + 4'd1;
                        end
                    end
                    DRAIN: if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        done      <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_param_reader.sv
// Directed bench for param_reader: models the two parameter stores and checks
// beat order, handshake stalls, abort, mid-stream reset and restart-while-busy.
module tb_param_reader;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        out_ready = 1'b0;
    logic [1:0]  mat_seli;
    logic [3:0]  mat_selj;
    logic [3:0]  vec_sel;
    logic [3:0]  out_idx;
    logic [15:0] mat_param;
    logic [15:0] vec_param;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_is_vec;
    logic        out_last;
    logic        busy;
    logic        done;

    int vectors = 0;
    int miscompares = 0;

    param_reader #(.ROWS(2), .COLS(4), .VLEN(4)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .mat_seli(mat_seli), .mat_selj(mat_selj), .mat_param(mat_param),
        .vec_sel(vec_sel), .vec_param(vec_param),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_is_vec(out_is_vec), .out_idx(out_idx), .out_last(out_last),
        .busy(busy), .done(done)
    );

    assign mat_param = 16'h0100 + 16'(mat_seli) * 16'd4 + 16'(mat_selj);
    assign vec_param = 16'h0200 + 16'(vec_sel);

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change just after the rising edge; the caller samples at the falling edge.
    task automatic applyStimulus(input logic s, input logic a, input logic r);
        @(posedge clk);
        #1;
        start     = s;
        abort     = a;
        out_ready = r;
        @(negedge clk);
    endtask

    // mode 0: ready always 1; mode 1: ready toggles 1,0,1,0; mode 2: ready low for 20 cycles after first beat
    task automatic streamTest(input string name, input int mode, input int restart_cyc);
        int          beats = 0;
        int          dones = 0;
        int          hs_cyc = -1;
        int          done_cyc = -1;
        logic        stalled = 1'b0;
        logic        rdy;
        logic [15:0] p_data = 16'd0;
        logic [3:0]  p_idx = 4'd0;
        logic        p_last = 1'b0;
        logic [15:0] exp_data;
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput({name, " busy in start cycle"}, 32'(busy), 32'd0);
        for (int cyc = 1; cyc < 80; cyc++) begin
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 2) == 1;
                default: rdy = !(cyc >= 2 && cyc < 22);
            endcase
            applyStimulus(cyc == restart_cyc, 1'b0, rdy);
            if (stalled) begin
                checkOutput({name, " valid held"}, 32'(out_valid), 32'd1);
                checkOutput({name, " data held"}, 32'(out_data), 32'(p_data));
                checkOutput({name, " idx held"}, 32'(out_idx), 32'(p_idx));
                checkOutput({name, " last held"}, 32'(out_last), 32'(p_last));
            end
            if (mode == 2 && cyc == 21) begin
                checkOutput({name, " stall data"}, 32'(out_data), 32'h0100);
                checkOutput({name, " stall busy"}, 32'(busy), 32'd1);
                checkOutput({name, " stall seli"}, 32'(mat_seli), 32'd0);
                checkOutput({name, " stall selj"}, 32'(mat_selj), 32'd1);
            end
            if (out_valid && out_ready) begin
                exp_data = (beats < 8) ? 16'h0100 + 16'(beats) : 16'h0200 + 16'(beats - 8);
                checkOutput({name, " beat data"}, 32'(out_data), 32'(exp_data));
                checkOutput({name, " beat idx"}, 32'(out_idx), 32'((beats < 8) ? beats : beats - 8));
                checkOutput({name, " beat is_vec"}, 32'(out_is_vec), 32'(beats >= 8));
                checkOutput({name, " beat last"}, 32'(out_last), 32'(beats == 11));
                if (mode == 0)
                    checkOutput({name, " beat cycle"}, 32'(cyc), 32'(beats + 2));
                beats++;
                if (beats == 12) hs_cyc = cyc;
            end
            if (done) begin
                dones++;
                done_cyc = cyc;
            end
            stalled = out_valid && !out_ready;
            p_data  = out_data;
            p_idx   = out_idx;
            p_last  = out_last;
            if (hs_cyc >= 0 && cyc >= hs_cyc + 3) break;
        end
        checkOutput({name, " beat count"}, 32'(beats), 32'd12);
        checkOutput({name, " done count"}, 32'(dones), 32'd1);
        checkOutput({name, " done timing"}, 32'(done_cyc), 32'(hs_cyc + 1));
        checkOutput({name, " busy after"}, 32'(busy), 32'd0);
        checkOutput({name, " valid after"}, 32'(out_valid), 32'd0);
    endtask

    task automatic checkAllZero(input string name);
        checkOutput({name, " valid"}, 32'(out_valid), 32'd0);
        checkOutput({name, " data"}, 32'(out_data), 32'd0);
        checkOutput({name, " is_vec"}, 32'(out_is_vec), 32'd0);
        checkOutput({name, " idx"}, 32'(out_idx), 32'd0);
        checkOutput({name, " last"}, 32'(out_last), 32'd0);
        checkOutput({name, " busy"}, 32'(busy), 32'd0);
        checkOutput({name, " done"}, 32'(done), 32'd0);
        checkOutput({name, " selects"}, {22'd0, mat_seli, mat_selj, vec_sel}, 32'd0);
    endtask

    initial begin
        int seen;
        #1 reset_n = 1'b0;
        #2 checkAllZero("reset");
        @(negedge clk);
        reset_n = 1'b1;

        streamTest("basic", 0, -1);
        streamTest("toggle", 1, -1);
        streamTest("stall", 2, -1);
        streamTest("restart", 0, 5);

        // Abort on the fifth beat, then confirm a clean full stream afterwards.
        applyStimulus(1'b1, 1'b0, 1'b1);
        for (int cyc = 1; cyc < 6; cyc++) applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("abort 5th beat data", 32'(out_data), 32'h0104);
        seen = 0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            applyStimulus(1'b0, 1'b0, 1'b1);
            if (cyc == 0) begin
                checkOutput("abort valid", 32'(out_valid), 32'd0);
                checkOutput("abort busy", 32'(busy), 32'd0);
                checkOutput("abort last", 32'(out_last), 32'd0);
            end
            if (done || out_valid) seen++;
        end
        checkOutput("abort no done/beats", 32'(seen), 32'd0);
        streamTest("after abort", 0, -1);

        // Reset in the middle of the vector phase.
        applyStimulus(1'b1, 1'b0, 1'b1);
        for (int cyc = 1; cyc <= 10; cyc++) applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("pre-reset in vec", 32'(out_is_vec), 32'd1);
        #2 reset_n = 1'b0;
        #1 checkAllZero("mid reset");
        @(negedge clk);
        reset_n = 1'b1;
        seen = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            applyStimulus(1'b0, 1'b0, 1'b1);
            if (out_valid || busy || done) seen++;
        end
        checkOutput("post-reset idle", 32'(seen), 32'd0);
        streamTest("after reset", 0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
